// File: rtl/command_uart_tx.sv
// ---------------------------------------------------------------------------
// command_uart_tx
//
// Sends the 4-bit command code from the sample-bank comparison stage
// off-chip as a two-byte 8N1 UART frame, least significant bit first:
//   byte0 = HEADER
//   byte1 = {~cmd, cmd}   (the upper nibble is an inverted check nibble)
//
// A frame starts on the rising edge of transmit_ready, only while
// state == 3'b010 and no frame is in flight. result is captured on that
// same cycle. Edges that arrive while a frame is in flight are dropped.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   HEADER        first byte of every frame
//
// Ports:
//   clk             system clock, rising edge
//   reset_n         asynchronous active-low reset
//   state           top-level phase; triggers accepted only in 3'b010
//   transmit_ready  level from the comparison stage; 0->1 edge triggers
//   result          command code, sampled on the trigger cycle
//   tx              UART serial line, idles high
//   busy            high while a frame is being sent
//   done            one-cycle pulse on the first idle cycle after a frame
// ---------------------------------------------------------------------------
module command_uart_tx #(
   parameter int          CLKS_PER_BIT = 4167,
   parameter logic [7:0]  HEADER       = 8'hA5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] state,
   input  logic       transmit_ready,
   input  logic [3:0] result,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]     PHASE_TX  = 3'b010;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } fsm_t;

   fsm_t          fsm_reg,      fsm_next;
   logic [CW-1:0] baud_reg,     baud_next;
   logic [2:0]    bit_idx_reg,  bit_idx_next;
   logic          byte_idx_reg, byte_idx_next;
   logic [3:0]    cmd_reg,      cmd_next;
   logic          rdy_q;
   logic          tx_reg,       tx_next;
   logic          busy_reg,     busy_next;
   logic          done_reg,     done_next;

   logic          trigger;
   logic          bit_end;
   logic [7:0]    cur_byte;
   logic [2:0]    bit_inc;

   // rdy_q resets high so a level already high at reset release is not
   // mistaken for a rising edge.
   assign trigger  = transmit_ready & ~rdy_q & (state == PHASE_TX) & ~busy_reg;
   assign bit_end  = (baud_reg == BAUD_LAST);
   assign cur_byte = byte_idx_reg ? {~cmd_reg, cmd_reg} : HEADER;
   assign bit_inc  = bit_idx_reg + 3'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fsm_reg      <= IDLE;
         baud_reg     <= '0;
         bit_idx_reg  <= 3'd0;
         byte_idx_reg <= 1'b0;
         cmd_reg      <= 4'd0;
         rdy_q        <= 1'b1;
         tx_reg       <= 1'b1;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         fsm_reg      <= fsm_next;
         baud_reg     <= baud_next;
         bit_idx_reg  <= bit_idx_next;
         byte_idx_reg <= byte_idx_next;
         cmd_reg      <= cmd_next;
         rdy_q        <= transmit_ready;
         tx_reg       <= tx_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
      end
   end

   // Outputs are registered: tx_next is the line value for the state being
   // entered, so the wire changes exactly on the cycle the new bit begins.
   always_comb begin
      fsm_next      = fsm_reg;
      baud_next     = baud_reg;
      bit_idx_next  = bit_idx_reg;
      byte_idx_next = byte_idx_reg;
      cmd_next      = cmd_reg;
      tx_next       = tx_reg;
      done_next     = 1'b0;

      case (fsm_reg)
         IDLE: begin
            baud_next = '0;
            tx_next   = 1'b1;
            if (trigger) begin
               cmd_next      = result;
               fsm_next      = START;
               byte_idx_next = 1'b0;
               bit_idx_next  = 3'd0;
               tx_next       = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               baud_next    = '0;
               fsm_next     = DATA;
               bit_idx_next = 3'd0;
               tx_next      = cur_byte[0];
            end else begin
               baud_next = baud_reg + CW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_next = '0;
               if (bit_idx_reg == 3'd7) begin
                  fsm_next = STOP;
                  tx_next  = 1'b1;
               end else begin
                  bit_idx_next = bit_inc;
                  tx_next      = cur_byte[bit_inc];
               end
            end else begin
               baud_next = baud_reg + CW'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_next = '0;
               if (!byte_idx_reg) begin
                  // Second byte follows the first stop bit with no gap.
                  byte_idx_next = 1'b1;
                  fsm_next      = START;
                  tx_next       = 1'b0;
               end else begin
                  fsm_next  = IDLE;
                  tx_next   = 1'b1;
                  done_next = 1'b1;
               end
            end else begin
               baud_next = baud_reg + CW'(1);
            end
         end
         default: begin
            fsm_next  = IDLE;
            baud_next = '0;
            tx_next   = 1'b1;
         end
      endcase

      busy_next = (fsm_next != IDLE);
   end

   assign tx   = tx_reg;
   assign busy = busy_reg;
   assign done = done_reg;

endmodule
